// File: rtl/stream_parity.sv
// ---------------------------------------------------------------------------
// stream_parity
//
// Registered streaming parity generator/checker on a valid/ready word stream.
// Each accepted word is copied into a single output register stage. The stage
// also holds the word's computed parity and a mismatch flag against the
// received parity bit. Frames are delimited by in_last. A running XOR of the
// per-word parity bits is published on frame_par with a one-cycle frame_done
// pulse. Words with a parity error are counted in a saturating counter.
//
// Parameters:
//   DATA_W  word width in bits (>= 1)
//   ODD     0 = even parity, 1 = odd parity (p = ^data ^ ODD)
//   CNT_W   error counter width
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_data, in_par     input word and its received parity bit
//   in_chk              1 = compare in_par against the computed parity
//   in_last             final word of a frame
//   out_valid/out_ready output handshake
//   out_data, out_par   registered word and its computed parity
//   out_err             parity mismatch for this word (0 when not checked)
//   out_last            registered in_last
//   frame_par           XOR of the out_par bits of the frame just completed
//   frame_done          one-cycle pulse, frame_par is valid
//   err_cnt             saturating count of erroneous words since reset
//
// Optional feature (macro STREAM_PARITY_STICKY_ERR_EN):
//   err_clr     clears err_sticky and err_cnt on the next edge
//   err_sticky  set when any word error is counted, held until cleared
//   If a clear coincides with a new error, the set wins (err_cnt = 1).
// ---------------------------------------------------------------------------
module stream_parity #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_chk,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              frame_par,
  output logic              frame_done,
  output logic [CNT_W-1:0]  err_cnt
`ifdef STREAM_PARITY_STICKY_ERR_EN
  ,
  input  logic              err_clr,
  output logic              err_sticky
`endif
);

  // Parity of one word including the even/odd selection.
  function automatic logic word_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ ODD;
  endfunction

  logic             acc_r;
  logic             in_xfer_s;
  logic             par_s;
  logic             err_s;
  logic             cnt_evt_s;
  logic             cnt_max_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Handshake, per-word parity and error detection.
  always_comb begin
    in_ready  = !out_valid || out_ready;
    in_xfer_s = in_valid && in_ready;
    par_s     = word_parity(in_data);
    err_s     = in_chk && (in_par != par_s);
    cnt_evt_s = in_xfer_s && err_s;
    cnt_max_s = &err_cnt;
  end

`ifdef STREAM_PARITY_STICKY_ERR_EN
  logic sticky_next_s;

  // Next error count and sticky flag; a new error overrides a clear.
  always_comb begin
    cnt_next_s    = err_cnt;
    sticky_next_s = err_sticky;
    if (err_clr) begin
      if (cnt_evt_s) begin
        cnt_next_s = CNT_W'(1'b1);
      end else begin
        cnt_next_s = {CNT_W{1'b0}};
      end
    end else if (cnt_evt_s && !cnt_max_s) begin
      cnt_next_s = err_cnt + CNT_W'(1'b1);
    end else begin
      cnt_next_s = err_cnt;
    end
    if (cnt_evt_s) begin
      sticky_next_s = 1'b1;
    end else if (err_clr) begin
      sticky_next_s = 1'b0;
    end else begin
      sticky_next_s = err_sticky;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= sticky_next_s;
    end
  end
`else
  // Next error count: saturating increment, cleared only by reset.
  always_comb begin
    cnt_next_s = err_cnt;
    if (cnt_evt_s && !cnt_max_s) begin
      cnt_next_s = err_cnt + CNT_W'(1'b1);
    end else begin
      cnt_next_s = err_cnt;
    end
  end
`endif

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= {CNT_W{1'b0}};
    end else begin
      err_cnt <= cnt_next_s;
    end
  end

  // Output stage, frame accumulator and frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= {DATA_W{1'b0}};
      out_par    <= 1'b0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
      frame_par  <= 1'b0;
      frame_done <= 1'b0;
      acc_r      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_xfer_s) begin
        // Loading a new word also covers a simultaneous output transfer.
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_par   <= par_s;
        out_err   <= err_s;
        out_last  <= in_last;
        if (in_last) begin
          frame_par  <= acc_r ^ par_s;
          frame_done <= 1'b1;
          acc_r      <= 1'b0;
        end else begin
          acc_r <= acc_r ^ par_s;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_stream_parity.sv
module tb_stream_parity;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_par;
  logic          in_chk;
  logic          in_last;
  logic          out_ready;

  logic          in_ready, out_valid, out_par, out_err, out_last, frame_par, frame_done;
  logic [DW-1:0] out_data;
  logic [15:0]   err_cnt;

  logic          s_in_ready, s_out_valid, s_out_par, s_out_err, s_out_last, s_frame_par, s_frame_done;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_err_cnt;

`ifdef STREAM_PARITY_STICKY_ERR_EN
  logic err_clr;
  logic err_sticky, s_err_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_parity #(.DATA_W(DW), .ODD(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .in_chk(in_chk), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .out_err(out_err), .out_last(out_last),
    .frame_par(frame_par), .frame_done(frame_done), .err_cnt(err_cnt)
`ifdef STREAM_PARITY_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
  );

  stream_parity #(.DATA_W(DW), .ODD(1'b0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_par(in_par), .in_chk(in_chk), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_par(s_out_par), .out_err(s_out_err), .out_last(s_out_last),
    .frame_par(s_frame_par), .frame_done(s_frame_done), .err_cnt(s_err_cnt)
`ifdef STREAM_PARITY_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(s_err_sticky)
`endif
  );

  // Reference parity from the definition: ones count modulo 2, then even/odd select.
  function automatic logic ref_par(input logic [DW-1:0] d);
    return logic'($countones(d) % 2) ^ 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic v, input logic [DW-1:0] d, input logic p,
                          input logic c, input logic l);
    in_valid = v; in_data = d; in_par = p; in_chk = c; in_last = l;
  endtask

  task automatic do_reset;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    tick;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    n_tests++; if (out_data !== 8'h00 || frame_par !== 1'b0) begin n_fail++; $display("FAIL reset_data got=%h/%b exp=00/0", out_data, frame_par); end
  endtask

  task automatic test_single;
    set_word(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%b/%h exp=1/a5", out_valid, out_data); end
    n_tests++; if (out_par !== 1'b0 || out_err !== 1'b0 || out_last !== 1'b1) begin n_fail++; $display("FAIL single_flags got par=%b err=%b last=%b exp 0 0 1", out_par, out_err, out_last); end
    n_tests++; if (frame_done !== 1'b1 || frame_par !== 1'b0) begin n_fail++; $display("FAIL single_frame got done=%b par=%b exp 1 0", frame_done, frame_par); end
    tick;
    n_tests++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after got done=%b valid=%b exp 0 0", frame_done, out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words [3];
    logic          pars  [3];
    words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07;
    pars[0] = 1'b1; pars[1] = 1'b0; pars[2] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(1'b1, words[i], 1'b0, 1'b0, (i == 2));
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      tick;
      n_tests++; if (out_data !== words[i] || out_par !== pars[i]) begin n_fail++; $display("FAIL b2b_word[%0d] got=%h/%b exp=%h/%b", i, out_data, out_par, words[i], pars[i]); end
      n_tests++; if (frame_done !== (i == 2)) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, frame_done, (i == 2)); end
    end
    n_tests++; if (frame_par !== 1'b0) begin n_fail++; $display("FAIL b2b_frame_par got=%b exp=0", frame_par); end
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_err;
    int base;
    base = int'(err_cnt);
    set_word(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    tick;
    n_tests++; if (out_err !== 1'b1 || err_cnt !== 16'(base + 1)) begin n_fail++; $display("FAIL err_chk got err=%b cnt=%0d exp 1 %0d", out_err, err_cnt, base + 1); end
    set_word(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    tick;
    n_tests++; if (out_err !== 1'b0 || err_cnt !== 16'(base + 1)) begin n_fail++; $display("FAIL err_nochk got err=%b cnt=%0d exp 0 %0d", out_err, err_cnt, base + 1); end
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    set_word(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_fail++; $display("FAIL stall_first got=%b/%h exp=1/3c", out_valid, out_data); end
    set_word(1'b1, 8'hC7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      tick;
      n_tests++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/3c", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    tick;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++; if (out_data !== 8'hC7 || out_valid !== 1'b1 || out_last !== 1'b1) begin n_fail++; $display("FAIL stall_next got=%b/%h exp=1/c7", out_valid, out_data); end
    n_tests++; if (frame_done !== 1'b1 || frame_par !== (ref_par(8'h3C) ^ ref_par(8'hC7))) begin n_fail++; $display("FAIL stall_frame got=%b/%b", frame_done, frame_par); end
    tick;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par;
    logic          err;
    logic          last;
  } exp_t;

  task automatic test_random;
    exp_t q[$];
    exp_t e;
    int   exp_cnt;
    logic facc, exp_done, exp_fpar, exp_rdy, in_x, p;
    do_reset;
    exp_cnt = 0; facc = 1'b0; exp_done = 1'b0; exp_fpar = 1'b0;
    for (int c = 0; c < 400; c++) begin
      set_word(($urandom % 4) != 0, 8'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
      out_ready = ($urandom % 4) != 0;
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      in_x = in_valid && exp_rdy;
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        n_tests++;
        if (out_data !== e.data || out_par !== e.par || out_err !== e.err || out_last !== e.last) begin
          n_fail++;
          $display("FAIL rnd_word c=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", c, out_data, out_par, out_err, out_last, e.data, e.par, e.err, e.last);
        end
      end
      exp_done = 1'b0;
      if (in_x) begin
        p = ref_par(in_data);
        e.data = in_data; e.par = p; e.err = in_chk && (in_par != p); e.last = in_last;
        q.push_back(e);
        if (e.err && exp_cnt < 65535) exp_cnt++;
        facc = facc ^ p;
        if (in_last) begin
          exp_done = 1'b1; exp_fpar = facc; facc = 1'b0;
        end
      end
      tick;
      n_tests++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, (q.size() != 0)); end
      n_tests++; if (frame_done !== exp_done) begin n_fail++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, frame_done, exp_done); end
      if (exp_done) begin
        n_tests++; if (frame_par !== exp_fpar) begin n_fail++; $display("FAIL rnd_fpar c=%0d got=%b exp=%b", c, frame_par, exp_fpar); end
      end
      n_tests++; if (err_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, err_cnt, exp_cnt); end
    end
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_saturation;
    int exp_s;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      set_word(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
      tick;
      exp_s = (i + 1 > 3) ? 3 : i + 1;
      n_tests++; if (s_err_cnt !== 2'(exp_s)) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, s_err_cnt, exp_s); end
    end
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick;
    n_tests++; if (s_err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold got=%0d exp=3", s_err_cnt); end
    n_tests++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide got=%0d exp=5", err_cnt); end
  endtask

`ifdef STREAM_PARITY_STICKY_ERR_EN
  task automatic test_sticky;
    do_reset;
    set_word(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    tick;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++; if (err_sticky !== 1'b1 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL sticky_set got=%b/%0d exp=1/1", err_sticky, err_cnt); end
    tick;
    n_tests++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got=%b exp=1", err_sticky); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_tests++; if (err_sticky !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL sticky_clr got=%b/%0d exp=0/0", err_sticky, err_cnt); end
    err_clr = 1'b1;
    set_word(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    tick;
    err_clr = 1'b0;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_tests++; if (err_sticky !== 1'b1 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL sticky_race got=%b/%0d exp=1/1", err_sticky, err_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    set_word(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef STREAM_PARITY_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    test_reset;
    test_single;
    test_back_to_back;
    test_err;
    test_stall;
    test_random;
    test_saturation;
`ifdef STREAM_PARITY_STICKY_ERR_EN
    test_sticky;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
